gpio_lite_pin_filter7: RTL and testbench

- Per-pin input conditioning stage directly upstream of the GPIO lite subunit.
- Synchronises raw pad inputs to pclk7 and debounces them with a programmable sample prescaler and a consecutive-sample threshold.
- Drives the filtered value into the subunit's pin_in7 port.
- Emits a one-cycle change pulse per pin for wake-up and edge logic.

---
 rtl/gpio_lite_pkg7.sv | 12 +
 rtl/gpio_lite_filter_bit7.sv | 56 +++++
 rtl/gpio_lite_pin_filter7.sv | 66 ++++++
 tb/tb_gpio_lite_pin_filter7.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/gpio_lite_pkg7.sv
// Shared constants for the GPIO lite input filter and its subunit.
package gpio_lite_pkg7;

  localparam int unsigned WidthDef = 16;
  localparam int unsigned CntWDef  = 4;
  localparam int unsigned PreWDef  = 8;

  // Filtered pin reset value; must match the subunit's pin_in7 reset value.
  localparam logic                PinFiltRstBit = 1'b0;
  localparam logic [WidthDef-1:0] PinFiltRst    = {WidthDef{PinFiltRstBit}};

endpackage

// File: rtl/gpio_lite_filter_bit7.sv
// One pin's debounce counter and filtered output flop.
module gpio_lite_filter_bit7
  import gpio_lite_pkg7::*;
#(
  parameter int unsigned CNT_W = CntWDef
) (
  input  logic             pclk7,
  input  logic             n_reset7,
  input  logic             tick,
  input  logic             enable,
  input  logic             sample,
  input  logic [CNT_W-1:0] threshold,
  output logic             filt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   thr_eff;

  // Next-state: bypass follows the sample, enabled pins count differing ticks.
  always_comb begin
    cnt_d   = cnt_q;
    filt_d  = filt_q;
    // Compare one bit wider so cnt + 1 can never wrap.
    cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    thr_eff = (threshold == '0) ? (CNT_W + 1)'(1) : {1'b0, threshold};
    if (!enable) begin
      filt_d = sample;
      cnt_d  = '0;
    end else if (tick) begin
      if (sample == filt_q) begin
        cnt_d = '0;
      end else if (cnt_inc >= thr_eff) begin
        filt_d = sample;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_inc[CNT_W-1:0];
      end
    end
  end

  // State registers.
  always_ff @(posedge pclk7 or negedge n_reset7) begin
    if (!n_reset7) begin
      cnt_q  <= '0;
      filt_q <= PinFiltRstBit;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/gpio_lite_pin_filter7.sv
// Pad input synchroniser, shared sample prescaler, per-pin debounce and change pulse.
module gpio_lite_pin_filter7
  import gpio_lite_pkg7::*;
#(
  parameter int unsigned WIDTH = WidthDef,
  parameter int unsigned CNT_W = CntWDef,
  parameter int unsigned PRE_W = PreWDef
) (
  input  logic             pclk7,
  input  logic             n_reset7,
  input  logic [WIDTH-1:0] pin_raw,
  input  logic [WIDTH-1:0] filt_enable,
  input  logic [PRE_W-1:0] prescale,
  input  logic [CNT_W-1:0] threshold,
  output logic [WIDTH-1:0] pin_filt,
  output logic [WIDTH-1:0] filt_change
);

  logic [WIDTH-1:0] sync_a_q, sync_a_d;
  logic [WIDTH-1:0] sync_b_q, sync_b_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0] pin_filt_q, pin_filt_d;
  logic             tick;

  // Synchroniser, prescaler and change-detector next state.
  always_comb begin
    sync_a_d   = pin_raw;
    sync_b_d   = sync_a_q;
    // >= rather than == so lowering prescale below pre_cnt ticks at once.
    tick       = (pre_cnt_q >= prescale);
    pre_cnt_d  = tick ? '0 : pre_cnt_q + PRE_W'(1);
    pin_filt_d = pin_filt;
  end

  // Shared state registers.
  always_ff @(posedge pclk7 or negedge n_reset7) begin
    if (!n_reset7) begin
      sync_a_q   <= '0;
      sync_b_q   <= '0;
      pre_cnt_q  <= '0;
      pin_filt_q <= {WIDTH{PinFiltRstBit}};
    end else begin
      sync_a_q   <= sync_a_d;
      sync_b_q   <= sync_b_d;
      pre_cnt_q  <= pre_cnt_d;
      pin_filt_q <= pin_filt_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_lite_filter_bit7 #(
      .CNT_W (CNT_W)
    ) u_bit (
      .pclk7     (pclk7),
      .n_reset7  (n_reset7),
      .tick      (tick),
      .enable    (filt_enable[i]),
      .sample    (sync_b_q[i]),
      .threshold (threshold),
      .filt      (pin_filt[i])
    );
  end

  assign filt_change = pin_filt ^ pin_filt_q;

endmodule

// File: tb/tb_gpio_lite_pin_filter7.sv
// Directed bench for gpio_lite_pin_filter7.
module tb_gpio_lite_pin_filter7;

  logic        pclk7;
  logic        n_reset7;
  logic [15:0] pin_raw;
  logic [15:0] filt_enable;
  logic [7:0]  prescale;
  logic [3:0]  threshold;
  logic [15:0] pin_filt;
  logic [15:0] filt_change;

  int n_cmp;
  int n_err;

  gpio_lite_pin_filter7 dut (
    .pclk7       (pclk7),
    .n_reset7    (n_reset7),
    .pin_raw     (pin_raw),
    .filt_enable (filt_enable),
    .prescale    (prescale),
    .threshold   (threshold),
    .pin_filt    (pin_filt),
    .filt_change (filt_change)
  );

  initial pclk7 = 1'b0;
  always #5 pclk7 = ~pclk7;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge pclk7);
    #1;
  endtask

  // Called 1 unit after an edge: hold reset for two edges, release on the falling edge.
  task automatic pulse_reset();
    n_reset7 = 1'b0;
    step(2);
    #4;
    n_reset7 = 1'b1;
  endtask

  logic [15:0] acc;

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    n_reset7    = 1'b0;
    pin_raw     = '0;
    filt_enable = '0;
    prescale    = '0;
    threshold   = '0;
    step(2);
    check("rst_filt", 32'(pin_filt), 32'h0);
    check("rst_chg", 32'(filt_change), 32'h0);

    // Reset mid-operation, then counters restart from zero.
    pin_raw     = 16'hFFFF;
    filt_enable = 16'hFFFF;
    threshold   = 4'd4;
    #4;
    n_reset7 = 1'b1;
    step(6);
    check("thr4_filt", 32'(pin_filt), 32'hFFFF);
    check("thr4_chg", 32'(filt_change), 32'hFFFF);
    #2;
    n_reset7 = 1'b0;
    #1;
    check("async_rst_filt", 32'(pin_filt), 32'h0);
    check("async_rst_chg", 32'(filt_change), 32'h0);
    step(2);
    #4;
    n_reset7 = 1'b1;
    step(5);
    check("restart_e4", 32'(pin_filt), 32'h0);
    step(1);
    check("restart_e5", 32'(pin_filt), 32'hFFFF);

    // Bypass latency.
    filt_enable = '0;
    pin_raw     = '0;
    step(4);
    check("byp_settle", 32'(pin_filt), 32'h0);
    pin_raw = 16'hA5A5;
    step(2);
    check("byp_e1", 32'(pin_filt), 32'h0);
    step(1);
    check("byp_e2", 32'(pin_filt), 32'hA5A5);
    check("byp_chg_e2", 32'(filt_change), 32'hA5A5);
    step(1);
    check("byp_chg_e3", 32'(filt_change), 32'h0);
    pin_raw = '0;
    step(4);

    // Debounce pass, threshold 3.
    filt_enable = 16'h0001;
    prescale    = 8'd0;
    threshold   = 4'd3;
    pin_raw     = 16'h0001;
    step(4);
    check("deb_e3", 32'(pin_filt), 32'h0);
    step(1);
    check("deb_e4", 32'(pin_filt), 32'h1);
    check("deb_chg_e4", 32'(filt_change), 32'h1);
    step(1);
    check("deb_chg_e5", 32'(filt_change), 32'h0);
    pin_raw = '0;
    step(8);
    check("deb_fall", 32'(pin_filt), 32'h0);

    // Glitch of two samples is rejected.
    pin_raw = 16'h0001;
    step(2);
    pin_raw = '0;
    acc     = '0;
    for (int i = 0; i < 8; i++) begin
      acc = acc | pin_filt | filt_change;
      step(1);
    end
    check("glitch", 32'(acc), 32'h0);

    // Threshold 0 acts as 1.
    threshold = 4'd0;
    pin_raw   = 16'h0001;
    step(2);
    check("thr0_e1", 32'(pin_filt), 32'h0);
    step(1);
    check("thr0_e2", 32'(pin_filt), 32'h1);

    // Prescaled sampling with a known prescaler phase.
    prescale    = 8'd3;
    threshold   = 4'd2;
    filt_enable = 16'h0020;
    pin_raw     = 16'h0020;
    pulse_reset();
    step(7);
    check("pre_e6", 32'(pin_filt), 32'h0);
    step(1);
    check("pre_e7", 32'(pin_filt), 32'h0020);
    check("pre_chg_e7", 32'(filt_change), 32'h0020);

    // Lower prescale below pre_cnt: tick on the next edge.
    prescale    = 8'd200;
    threshold   = 4'd1;
    filt_enable = 16'h0001;
    pin_raw     = 16'h0001;
    pulse_reset();
    step(100);
    check("lower_e99", 32'(pin_filt), 32'h0);
    prescale = 8'd2;
    step(1);
    check("lower_e100", 32'(pin_filt), 32'h1);

    // Disable mid-count: output follows sync_b next edge.
    prescale  = 8'd0;
    threshold = 4'd8;
    pin_raw   = '0;
    step(4);
    check("dis_hold", 32'(pin_filt), 32'h1);
    filt_enable = '0;
    step(1);
    check("dis_follow", 32'(pin_filt), 32'h0);
    check("dis_chg", 32'(filt_change), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
